// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding, comparator flag codes and legal-flag check for the SAR search
// Flag vectors are packed as {gt, eq, lt}; exactly one bit set is the only legal response.
package sar_pkg;
    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;
    function automatic logic flags_legal(input logic [2:0] f);
        return (f == CMP_GT) || (f == CMP_EQ) || (f == CMP_LT);
    endfunction
endpackage

// File: rtl/sar_bit_step.sv
// sar_bit_step: one combinational SAR step (keep/clear bit k, form the next trial)
// ports: acc (resolved upper bits), k (bit under test), flags {gt,eq,lt}
//        -> acc_new, trial_nxt (acc_new with bit k-1 set), last (k==0), illegal (not one-hot)
module sar_bit_step
    import sar_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [KW-1:0]    k,
    input  logic [2:0]       flags,
    output logic [WIDTH-1:0] acc_new,
    output logic [WIDTH-1:0] trial_nxt,
    output logic             last,
    output logic             illegal
);
    logic [WIDTH-1:0] mask;
    assign mask      = WIDTH'(1) << k;
    assign acc_new   = (flags == CMP_GT) ? (acc | mask) : (acc & ~mask);
    // mask>>1 is the bit below k; meaningless (zero) at k==0, where last takes over
    assign trial_nxt = acc_new | (mask >> 1);
    assign last      = (k == '0);
    assign illegal   = !flags_legal(flags);
endmodule

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: successive-approximation search controller driving an external comparator
// ports: clk, rst (sync, active-high); start begins a search from IDLE; busy high while probing;
//        trial/trial_valid go to the comparator, cmp_valid with gt/lt/eq come back;
//        done pulses one cycle when result/exact/err take the outcome of the finished search
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    output logic             trial_valid,
    input  logic             cmp_valid,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n, trial_n, result_n, s_acc, s_trial;
    logic [KW-1:0]    k, k_n;
    logic             exact_n, err_n, s_last, s_illegal;
    logic [2:0]       flags;
    assign flags = {gt, eq, lt};
    sar_bit_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .acc       (acc),
        .k         (k),
        .flags     (flags),
        .acc_new   (s_acc),
        .trial_nxt (s_trial),
        .last      (s_last),
        .illegal   (s_illegal)
    );
    assign trial_valid = (state == PROBE);
    assign busy        = (state == PROBE);
    assign done        = (state == DONE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            k      <= '0;
            trial  <= '0;
            result <= '0;
            exact  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            k      <= k_n;
            trial  <= trial_n;
            result <= result_n;
            exact  <= exact_n;
            err    <= err_n;
        end
    end
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        k_n      = k;
        trial_n  = trial;
        result_n = result;
        exact_n  = exact;
        err_n    = err;
        case (state)
            IDLE: if (start) begin
                acc_n   = '0;
                k_n     = KW'(WIDTH - 1);
                trial_n = WIDTH'(1) << (WIDTH - 1);
                state_n = PROBE;
            end
            PROBE: if (cmp_valid) begin
                if (s_illegal || flags == CMP_EQ) begin
                    result_n = trial;
                    exact_n  = !s_illegal;
                    err_n    = s_illegal;
                    state_n  = DONE;
                end else if (s_last) begin
                    result_n = s_acc;
                    exact_n  = 1'b0;
                    err_n    = 1'b0;
                    state_n  = DONE;
                end else begin
                    acc_n   = s_acc;
                    k_n     = k - KW'(1);
                    trial_n = s_trial;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: randomized self-checking bench with a comparator model and arithmetic search model
module tb_sar_search_ctrl;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cmp_valid = 1'b0, inj = 1'b0;
    logic       gt, lt, eq, trial_valid, busy, done, exact, err, rst_s;
    logic [7:0] trial, result, target = 8'd0;
    logic [9:0] prev;
    int         total = 0, bad = 0, dones = 0, exp_dones = 0, n;

    always #5 clk = ~clk;

    sar_search_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .trial(trial), .trial_valid(trial_valid),
        .cmp_valid(cmp_valid), .gt(gt), .lt(lt), .eq(eq), .busy(busy), .done(done),
        .result(result), .exact(exact), .err(err)
    );

    assign gt = inj | (target > trial);
    assign lt = inj | (target < trial);
    assign eq = !inj && (target == trial);

    function automatic void chk(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, a, e);
        end
    endfunction

    // trial for bit k: target's bits above k, bit k set, lower bits clear
    function automatic logic [7:0] mdl_trial(input logic [7:0] t, input int k);
        int m = 1 << (k + 1);
        return 8'(((int'(t) / m) * m) | (1 << k));
    endfunction

    always @(posedge clk) rst_s <= rst;

    always @(negedge clk) begin
        if (!done && !rst_s) chk("hold", {result, exact, err}, prev);
        prev = {result, exact, err};
        if (done) dones++;
    end

    task automatic search(input logic [7:0] t, input int stall, input int inj_p, output int probes);
        int p = 0, w = 0, cyc = 0, st;
        bit fin = 0;
        logic [7:0] exp_t, exp_r = 8'd0;
        logic exp_x = 1'b0, exp_e = 1'b0;
        target = t;
        start = 1'b1;
        @(negedge clk);
        st = (stall < 0) ? $urandom_range(0, 3) : stall;
        while (!fin && cyc < 200) begin
            exp_t = mdl_trial(t, 7 - p);
            chk("busy", busy, 1);
            chk("trial_valid", trial_valid, 1);
            chk("done_early", done, 0);
            chk("trial", trial, exp_t);
            start = 1'($urandom_range(0, 1));
            cmp_valid = (w >= st);
            inj = (p == inj_p);
            if (cmp_valid) begin
                if (inj) begin
                    fin = 1; exp_r = exp_t; exp_x = 0; exp_e = 1;
                end else if (t == exp_t) begin
                    fin = 1; exp_r = exp_t; exp_x = 1; exp_e = 0;
                end else if (p == 7) begin
                    fin = 1; exp_r = t; exp_x = 0; exp_e = 0;
                end
                p++;
                w = 0;
                st = (stall < 0) ? $urandom_range(0, 3) : stall;
            end else w++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; cmp_valid = 1'b0; inj = 1'b0;
        if (!fin) chk("timeout", cyc, 0);
        exp_dones++;
        probes = p;
        chk("done", done, 1);
        chk("done_tv", trial_valid, 0);
        chk("done_busy", busy, 0);
        chk("result", result, exp_r);
        chk("exact", exact, exp_x);
        chk("err", err, exp_e);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_trial", trial, 0);
        chk("rst_tv", trial_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_exact", exact, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("m_t5p6", mdl_trial(8'd5, 1), 6);
        chk("m_t77p1", mdl_trial(8'd77, 6), 64);
        search(8'd5, 0, -1, n);
        chk("t1_probes", n, 8);
        chk("t1_result", result, 5);
        search(8'd0, 0, -1, n);
        chk("t2_probes", n, 8);
        chk("t2_exact", exact, 0);
        search(8'd255, 0, -1, n);
        chk("t3_result", result, 255);
        search(8'd4, 3, -1, n);
        chk("t4_probes", n, 6);
        search(8'd200, 0, 1, n);
        chk("t5_result", result, 192);
        chk("t5_err", err, 1);
        search(8'd37, 2, 1, n);
        chk("t5b_result", result, 64);
        target = 8'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cmp_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_probe3", trial, 96);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp_valid = 1'b0;
        chk("t6_tv", trial_valid, 0);
        chk("t6_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("t6_nodone", dones, exp_dones);
        search(8'd77, 0, -1, n);
        chk("t6_result", result, 77);
        chk("t6_exact", exact, 1);
        for (int i = 0; i < 25; i++) begin
            search(8'($urandom_range(0, 255)), -1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1, n);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        chk("done_count", dones, exp_dones);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
